// File: rtl/rvfi_gen_pkg.sv
// Shared types and constants for the RVFI register-trace generator.
package rvfi_gen_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int REQ_XLEN  = 32;

  // One abstract retire request as it sits in the FIFO.
  typedef struct packed {
    logic [31:0]           insn;
    logic [REQ_XLEN-1:0]   pc;
    logic [REQ_XLEN-1:0]   post_pc;
    logic [REG_IDX_W-1:0]  rs1_addr;
    logic [REG_IDX_W-1:0]  rs2_addr;
    logic [REG_IDX_W-1:0]  rd_addr;
    logic [REQ_XLEN-1:0]   rd_wdata;
    logic                  trap;
  } retire_req_t;

  // Corrupt a reported read value when it targets the injected register.
  // x0 is never a valid injection target.
  function automatic logic [REQ_XLEN-1:0] inject_read(
    input logic [REQ_XLEN-1:0]  value,
    input logic [REG_IDX_W-1:0] addr,
    input logic                 en,
    input logic [REG_IDX_W-1:0] target,
    input logic [REQ_XLEN-1:0]  mask
  );
    return (en && (target != '0) && (addr == target)) ? (value ^ mask) : value;
  endfunction

endpackage

// File: rtl/rvfi_gen_fifo.sv
// Two-entry synchronous FIFO of retire requests.
module rvfi_gen_fifo
  import rvfi_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  retire_req_t din,
  output retire_req_t dout,
  output logic        full,
  output logic        empty
);

  retire_req_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push_ok;
  logic        pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvfi_reg_trace_gen.sv
// RVFI record producer: FIFO of retire requests, architectural register
// shadow, order counter and read-data fault injection.
module rvfi_reg_trace_gen
  import rvfi_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ORDER_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_insn,
  input  logic [XLEN-1:0]      req_pc,
  input  logic [XLEN-1:0]      req_post_pc,
  input  logic [REG_IDX_W-1:0] req_rs1_addr,
  input  logic [REG_IDX_W-1:0] req_rs2_addr,
  input  logic [REG_IDX_W-1:0] req_rd_addr,
  input  logic [XLEN-1:0]      req_rd_wdata,
  input  logic                 req_trap,
  input  logic                 drain,
  input  logic                 inj_en,
  input  logic [REG_IDX_W-1:0] inj_reg,
  input  logic [XLEN-1:0]      inj_mask,
  output logic                 rvfi_valid,
  output logic                 rvfi_trap,
  output logic [ORDER_W-1:0]   rvfi_order,
  output logic [31:0]          rvfi_insn,
  output logic [REG_IDX_W-1:0] rvfi_rs1_addr,
  output logic [REG_IDX_W-1:0] rvfi_rs2_addr,
  output logic [REG_IDX_W-1:0] rvfi_rd_addr,
  output logic [XLEN-1:0]      rvfi_rs1_rdata,
  output logic [XLEN-1:0]      rvfi_rs2_rdata,
  output logic [XLEN-1:0]      rvfi_rd_wdata,
  output logic [XLEN-1:0]      rvfi_pc_rdata,
  output logic [XLEN-1:0]      rvfi_post_pc
);

  retire_req_t          req;
  retire_req_t          head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 rd_writes;
  logic [XLEN-1:0]      rs1_true;
  logic [XLEN-1:0]      rs2_true;
  logic [XLEN-1:0]      regs [NUM_REGS];
  logic [ORDER_W-1:0]   order_cnt;

  assign req = '{
    insn:     req_insn,
    pc:       req_pc,
    post_pc:  req_post_pc,
    rs1_addr: req_rs1_addr,
    rs2_addr: req_rs2_addr,
    rd_addr:  req_rd_addr,
    rd_wdata: req_rd_wdata,
    trap:     req_trap
  };

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = drain && !fifo_empty;

  rvfi_gen_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (req),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Reads see the shadow before this record's own write; x0 is hardwired 0.
  assign rs1_true  = (head.rs1_addr == '0) ? '0 : regs[head.rs1_addr];
  assign rs2_true  = (head.rs2_addr == '0) ? '0 : regs[head.rs2_addr];
  assign rd_writes = !head.trap && (head.rd_addr != '0);

  // Architectural shadow, updated on the same edge the record is emitted so
  // the next pop observes the new value without a bypass path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (pop && rd_writes) begin
      regs[head.rd_addr] <= head.rd_wdata;
    end
  end

  // Retirement order counter, wrapping naturally at its width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      order_cnt <= '0;
    end else if (pop) begin
      order_cnt <= order_cnt + 1'b1;
    end
  end

  // Registered RVFI record; fields hold between emissions, only valid pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvfi_valid     <= 1'b0;
      rvfi_trap      <= 1'b0;
      rvfi_order     <= '0;
      rvfi_insn      <= '0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_rd_wdata  <= '0;
      rvfi_pc_rdata  <= '0;
      rvfi_post_pc   <= '0;
    end else begin
      rvfi_valid <= pop;
      if (pop) begin
        rvfi_trap      <= head.trap;
        rvfi_order     <= order_cnt;
        rvfi_insn      <= head.insn;
        rvfi_rs1_addr  <= head.rs1_addr;
        rvfi_rs2_addr  <= head.rs2_addr;
        rvfi_rd_addr   <= rd_writes ? head.rd_addr : '0;
        rvfi_rs1_rdata <= inject_read(rs1_true, head.rs1_addr, inj_en, inj_reg, inj_mask);
        rvfi_rs2_rdata <= inject_read(rs2_true, head.rs2_addr, inj_en, inj_reg, inj_mask);
        rvfi_rd_wdata  <= rd_writes ? head.rd_wdata : '0;
        rvfi_pc_rdata  <= head.pc;
        rvfi_post_pc   <= head.post_pc;
      end
    end
  end

endmodule

// File: tb/tb_rvfi_reg_trace_gen.sv
// Self-checking bench for rvfi_reg_trace_gen: queue/array reference model
// plus directed scenarios with hand-computed expectations.
module tb_rvfi_reg_trace_gen;
  import rvfi_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_insn = '0;
  logic [31:0] req_pc = '0;
  logic [31:0] req_post_pc = '0;
  logic [4:0]  req_rs1_addr = '0;
  logic [4:0]  req_rs2_addr = '0;
  logic [4:0]  req_rd_addr = '0;
  logic [31:0] req_rd_wdata = '0;
  logic        req_trap = 1'b0;
  logic        drain = 1'b0;
  logic        inj_en = 1'b0;
  logic [4:0]  inj_reg = '0;
  logic [31:0] inj_mask = '0;
  logic        rvfi_valid;
  logic        rvfi_trap;
  logic [7:0]  rvfi_order;
  logic [31:0] rvfi_insn;
  logic [4:0]  rvfi_rs1_addr;
  logic [4:0]  rvfi_rs2_addr;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata;
  logic [31:0] rvfi_rs2_rdata;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_post_pc;

  int vectors = 0;
  int miscompares = 0;
  int seq = 0;

  // Reference model state
  retire_req_t m_q[$];
  logic [31:0] m_regs [32];
  int          m_order = 0;
  logic        exp_valid = 1'b0;
  logic        exp_trap = 1'b0;
  int          exp_order = 0;
  logic [31:0] exp_insn = '0;
  logic [4:0]  exp_rs1_addr = '0;
  logic [4:0]  exp_rs2_addr = '0;
  logic [4:0]  exp_rd_addr = '0;
  logic [31:0] exp_rs1 = '0;
  logic [31:0] exp_rs2 = '0;
  logic [31:0] exp_rd_wdata = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_post_pc = '0;

  rvfi_reg_trace_gen #(.XLEN(32), .ORDER_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_insn       (req_insn),
    .req_pc         (req_pc),
    .req_post_pc    (req_post_pc),
    .req_rs1_addr   (req_rs1_addr),
    .req_rs2_addr   (req_rs2_addr),
    .req_rd_addr    (req_rd_addr),
    .req_rd_wdata   (req_rd_wdata),
    .req_trap       (req_trap),
    .drain          (drain),
    .inj_en         (inj_en),
    .inj_reg        (inj_reg),
    .inj_mask       (inj_mask),
    .rvfi_valid     (rvfi_valid),
    .rvfi_trap      (rvfi_trap),
    .rvfi_order     (rvfi_order),
    .rvfi_insn      (rvfi_insn),
    .rvfi_rs1_addr  (rvfi_rs1_addr),
    .rvfi_rs2_addr  (rvfi_rs2_addr),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rs1_rdata (rvfi_rs1_rdata),
    .rvfi_rs2_rdata (rvfi_rs2_rdata),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_post_pc   (rvfi_post_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, return at the next one.
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] wdata,
                               input logic trap, input logic dr);
    req_valid    = v;
    req_insn     = {seq[15:0], 16'h0033};
    req_pc       = 32'h1000 + 32'(seq) * 32'd4;
    req_post_pc  = 32'h1004 + 32'(seq) * 32'd4;
    req_rs1_addr = rs1;
    req_rs2_addr = rs2;
    req_rd_addr  = rd;
    req_rd_wdata = wdata;
    req_trap     = trap;
    drain        = dr;
    seq++;
    @(negedge clk);
  endtask

  task automatic applyIdle(input logic dr);
    req_valid = 1'b0;
    drain     = dr;
    @(negedge clk);
  endtask

  // Reference model: a retire queue of depth two, a register array and an
  // order count modulo 256, evaluated from the architectural rules.
  initial begin
    retire_req_t r;
    int          sz;
    bit          can_pop;
    bit          can_push;
    bit          writes;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_q.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_order      = 0;
        exp_valid    = 1'b0;
        exp_trap     = 1'b0;
        exp_order    = 0;
        exp_insn     = '0;
        exp_rs1_addr = '0;
        exp_rs2_addr = '0;
        exp_rd_addr  = '0;
        exp_rs1      = '0;
        exp_rs2      = '0;
        exp_rd_wdata = '0;
        exp_pc       = '0;
        exp_post_pc  = '0;
      end else begin
        sz       = m_q.size();
        can_pop  = drain && (sz > 0);
        can_push = req_valid && (sz < 2);
        exp_valid = can_pop;
        if (can_pop) begin
          r = m_q.pop_front();
          writes       = !r.trap && (r.rd_addr != 0);
          exp_trap     = r.trap;
          exp_order    = m_order;
          m_order      = (m_order + 1) % 256;
          exp_insn     = r.insn;
          exp_rs1_addr = r.rs1_addr;
          exp_rs2_addr = r.rs2_addr;
          exp_rs1      = (r.rs1_addr == 0) ? 32'h0 : m_regs[r.rs1_addr];
          exp_rs2      = (r.rs2_addr == 0) ? 32'h0 : m_regs[r.rs2_addr];
          if (inj_en && inj_reg != 0 && r.rs1_addr == inj_reg) exp_rs1 = exp_rs1 ^ inj_mask;
          if (inj_en && inj_reg != 0 && r.rs2_addr == inj_reg) exp_rs2 = exp_rs2 ^ inj_mask;
          exp_rd_addr  = writes ? r.rd_addr : 5'd0;
          exp_rd_wdata = writes ? r.rd_wdata : 32'h0;
          exp_pc       = r.pc;
          exp_post_pc  = r.post_pc;
          if (writes) m_regs[r.rd_addr] = r.rd_wdata;
        end
        if (can_push) begin
          m_q.push_back(retire_req_t'{insn: req_insn, pc: req_pc, post_pc: req_post_pc,
                                      rs1_addr: req_rs1_addr, rs2_addr: req_rs2_addr,
                                      rd_addr: req_rd_addr, rd_wdata: req_rd_wdata,
                                      trap: req_trap});
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("req_ready", 32'(req_ready), 32'(m_q.size() < 2));
    checkOutput("valid", 32'(rvfi_valid), 32'(exp_valid));
    checkOutput("trap", 32'(rvfi_trap), 32'(exp_trap));
    checkOutput("order", 32'(rvfi_order), 32'(exp_order));
    checkOutput("insn", rvfi_insn, exp_insn);
    checkOutput("rs1_addr", 32'(rvfi_rs1_addr), 32'(exp_rs1_addr));
    checkOutput("rs2_addr", 32'(rvfi_rs2_addr), 32'(exp_rs2_addr));
    checkOutput("rd_addr", 32'(rvfi_rd_addr), 32'(exp_rd_addr));
    checkOutput("rs1_rdata", rvfi_rs1_rdata, exp_rs1);
    checkOutput("rs2_rdata", rvfi_rs2_rdata, exp_rs2);
    checkOutput("rd_wdata", rvfi_rd_wdata, exp_rd_wdata);
    checkOutput("pc_rdata", rvfi_pc_rdata, exp_pc);
    checkOutput("post_pc", rvfi_post_pc, exp_post_pc);
  end

  initial begin
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset with drain high
    repeat (3) applyIdle(1'b1);
    checkOutput("lit_idle_valid", 32'(rvfi_valid), 32'd0);
    checkOutput("lit_idle_ready", 32'(req_ready), 32'd1);
    checkOutput("lit_idle_order", 32'(rvfi_order), 32'd0);
    checkOutput("lit_idle_rs1", rvfi_rs1_rdata, 32'd0);

    // RAW chain through x5
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd5, 32'h1, 1'b0, 1'b1);
    checkOutput("lit_a_valid", 32'(rvfi_valid), 32'd1);
    checkOutput("lit_a_order", 32'(rvfi_order), 32'd0);
    checkOutput("lit_a_wdata", rvfi_rd_wdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd5, 5'd0, 5'd6, 32'h2, 1'b0, 1'b1);
    checkOutput("lit_b_order", 32'(rvfi_order), 32'd1);
    checkOutput("lit_b_rs1", rvfi_rs1_rdata, 32'hDEADBEEF);
    checkOutput("lit_b_rs2", rvfi_rs2_rdata, 32'hDEADBEEF);
    applyIdle(1'b1);
    checkOutput("lit_c_rs1", rvfi_rs1_rdata, 32'h1);

    // rd = x0 and trapping records report no write
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 32'h55, 1'b0, 1'b1);
    applyIdle(1'b1);
    checkOutput("lit_x0_rd", 32'(rvfi_rd_addr), 32'd0);
    checkOutput("lit_x0_wdata", rvfi_rd_wdata, 32'd0);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd3, 32'h33, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd3, 32'h99, 1'b1, 1'b1);
    applyIdle(1'b1);
    checkOutput("lit_trap_flag", 32'(rvfi_trap), 32'd1);
    checkOutput("lit_trap_rd", 32'(rvfi_rd_addr), 32'd0);
    checkOutput("lit_trap_wdata", rvfi_rd_wdata, 32'd0);
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    applyIdle(1'b1);
    checkOutput("lit_x3_kept", rvfi_rs1_rdata, 32'h33);

    // Backpressure with drain low, then release
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd8, 32'hA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd9, 32'hA2, 1'b0, 1'b0);
    checkOutput("lit_full_ready", 32'(req_ready), 32'd0);
    checkOutput("lit_full_valid", 32'(rvfi_valid), 32'd0);
    applyStimulus(1'b1, 5'd8, 5'd9, 5'd10, 32'hA3, 1'b0, 1'b1);
    checkOutput("lit_d1_order", 32'(rvfi_order), 32'd7);
    checkOutput("lit_d1_wdata", rvfi_rd_wdata, 32'hA1);
    applyStimulus(1'b1, 5'd8, 5'd9, 5'd10, 32'hA3, 1'b0, 1'b1);
    checkOutput("lit_d2_order", 32'(rvfi_order), 32'd8);
    checkOutput("lit_d2_wdata", rvfi_rd_wdata, 32'hA2);
    applyIdle(1'b1);
    checkOutput("lit_d3_order", 32'(rvfi_order), 32'd9);
    checkOutput("lit_d3_rs1", rvfi_rs1_rdata, 32'hA1);
    checkOutput("lit_d3_rs2", rvfi_rs2_rdata, 32'hA2);

    // Fault injection on x7
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 32'h10, 1'b0, 1'b1);
    inj_en = 1'b1; inj_reg = 5'd7; inj_mask = 32'h1;
    applyStimulus(1'b1, 5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 1'b1);
    applyIdle(1'b1);
    checkOutput("lit_inj_rs1", rvfi_rs1_rdata, 32'h11);
    checkOutput("lit_inj_rs2", rvfi_rs2_rdata, 32'h11);
    inj_en = 1'b0;
    applyStimulus(1'b1, 5'd7, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    applyIdle(1'b1);
    checkOutput("lit_inj_shadow", rvfi_rs1_rdata, 32'h10);
    inj_en = 1'b1; inj_reg = 5'd0; inj_mask = 32'hFFFFFFFF;
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    applyIdle(1'b1);
    checkOutput("lit_inj_x0", rvfi_rs1_rdata, 32'h0);
    inj_en = 1'b0; inj_mask = 32'h0;

    // Sustained stream across the order wrap; next order is 14
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 7) == 0), 1'b1);
      if (i == 242) checkOutput("lit_order_ff", 32'(rvfi_order), 32'hFF);
      if (i == 243) checkOutput("lit_order_wrap", 32'(rvfi_order), 32'h0);
    end
    applyIdle(1'b1);

    // Reset in the middle of a stream
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd4, 32'h22, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("lit_rst_valid", 32'(rvfi_valid), 32'd0);
    checkOutput("lit_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 5'd5, 5'd0, 5'd4, 32'h77, 1'b0, 1'b1);
    applyIdle(1'b1);
    checkOutput("lit_rst_order", 32'(rvfi_order), 32'd0);
    checkOutput("lit_rst_rs1", rvfi_rs1_rdata, 32'd0);
    checkOutput("lit_rst_wdata", rvfi_rd_wdata, 32'h77);
    repeat (3) applyIdle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rvfi_reg_trace_gen.md
# rvfi_reg_trace_gen

Producer side of the RVFI register-consistency interface: accepts abstract retire requests, keeps a 32-entry architectural register shadow, and emits single-channel RVFI records whose rs1/rs2 read data, rd write data and order field are mutually consistent. It drives register and ordering checkers in formal and simulation benches. A fault-injection port deliberately corrupts read data so that negative tests can prove the checkers fire.

## Interface
- `XLEN`, 32, register and PC width
- `ORDER_W`, 8, width of `rvfi_order`; the counter wraps modulo 2^ORDER_W
- `clk` in 1 clock
- `reset` in 1 asynchronous, active-high reset
- `req_valid` in 1 retire request present
- `req_ready` out 1 request can be accepted (FIFO not full)
- `req_insn` in 32 instruction word, passed through
- `req_pc`, `req_post_pc` in XLEN each, passed to `rvfi_pc_rdata` / `rvfi_post_pc`
- `req_rs1_addr`, `req_rs2_addr`, `req_rd_addr` in 5 each, register indices
- `req_rd_wdata` in XLEN result value
- `req_trap` in 1 instruction traps and has no architectural register write
- `drain` in 1 permits emission of one record this cycle
- `inj_en` in 1 fault injection enable
- `inj_reg` in 5 register whose reads are corrupted
- `inj_mask` in XLEN XOR mask applied to corrupted reads
- `rvfi_valid`, `rvfi_trap` out 1 each
- `rvfi_order` out ORDER_W
- `rvfi_insn` out 32
- `rvfi_rs1_addr`, `rvfi_rs2_addr`, `rvfi_rd_addr` out 5 each
- `rvfi_rs1_rdata`, `rvfi_rs2_rdata`, `rvfi_rd_wdata`, `rvfi_pc_rdata`, `rvfi_post_pc` out XLEN each

## Operation
- Request handshake: a request is accepted on a rising edge where `req_valid && req_ready` is true. Accepted requests are pushed into a 2-entry FIFO. `req_ready` = FIFO count < 2. Requests that are not accepted are ignored, with no side effects.
- Emission: on a rising edge with `drain && !empty`, the FIFO head is popped and all `rvfi_*` outputs are registered from it. `rvfi_valid` is 1 for exactly that cycle.
- When `drain` is 0 or the FIFO is empty, `rvfi_valid` is 0 and every other output holds its previous value.
- Read data: `rvfi_rsN_rdata` is the value of `regs[rsN_addr]` before the write of the same record, so an instruction that reads and writes the same register reports the old value. Index 0 always reads 0.
- Write: for a popped record with `rd_addr != 0 && !trap`, `regs[rd_addr] <= rd_wdata`. For a record with `rd_addr == 0` or `trap`:
  - `rvfi_rd_addr` and `rvfi_rd_wdata` are reported as 0;
  - no register is written.
- Order: `rvfi_order` carries the counter value, and the counter increments on each emitted record, wrapping from all-ones to 0.
- Injection: sampled on the emission edge. If `inj_en && inj_reg != 0 && rsN_addr == inj_reg`, then `rvfi_rsN_rdata` is the true value XOR `inj_mask`, applied independently for rs1 and rs2. Injection never alters the register shadow or `rvfi_rd_wdata`.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FIFO empty, `req_ready` = 1;
  - all registers, order counter and `rvfi_*` outputs are 0.
- Latency: a request accepted at edge N is emitted at edge N+1 at the earliest, provided `drain` is 1 and it is the FIFO head.
- Simultaneous push and pop with count 1: both take effect and count stays 1. With count 2, no push is possible.
- Back-to-back pops read the shadow after the previous pop's write, so RAW dependencies between consecutive records are exact with no bypass gap.
- Reset asserted mid-operation: pending FIFO entries are discarded, and `rvfi_valid` drops asynchronously.
- Throughput: one record per cycle sustained when `req_valid` and `drain` are held high.

## Structure
- Package `rvfi_gen_pkg`:
  - packed struct `retire_req_t` (insn, pc, post_pc, rs1/rs2/rd addr, rd_wdata, trap);
  - constants `REG_IDX_W = 5` and `NUM_REGS = 32`.
- Sub-module `rvfi_gen_fifo`: 2-entry synchronous FIFO of `retire_req_t` with push/pop/full/empty and asynchronous active-high reset.
- The register shadow and the order counter live in the top-level module.

## Test plan
- Reset then idle with `drain` = 1: `rvfi_valid` stays 0, `req_ready` = 1, all outputs 0.
- Request A (rd=5, wdata=0xDEADBEEF), then request B (rs1=5, rs2=5, rd=5, wdata=1), `drain` held at 1:
  - A emitted with order 0;
  - B emitted next cycle with order 1 and rs1_rdata = rs2_rdata = 0xDEADBEEF;
  - a third record reading x5 sees 1.
- Request with rd=0, wdata=0x55 or with trap=1, rd=3: emitted with rd_addr = 0 and rd_wdata = 0; a later read of x3 returns its prior value.
- Hold `drain` = 0 and offer 3 requests: the first 2 are accepted, then `req_ready` = 0. Raise `drain`: the two records emit on consecutive cycles in order, and the third is accepted once space opens.
- Injection with `inj_reg` = 7 and `inj_mask` = 0x1, where x7 = 0x10 and a record has rs1=7, rs2=7:
  - both rdata report 0x11 while the shadow stays 0x10;
  - with `inj_reg` = 0, a read of x0 is still 0.
- Emit 256 records with `ORDER_W` = 8: order runs 0..255 then wraps to 0. Asserting reset mid-stream clears the FIFO and restarts order at 0.
